// File: rtl/clk_div_pkg.sv
// Shared constants and types for the clock divider.
// Counter width and the default terminal count (1 Hz from a 50 MHz source).
package clk_div_pkg;

   localparam int CLK_DIV_CNT_W = 25;

   typedef logic [CLK_DIV_CNT_W-1:0] cnt_t;

   localparam cnt_t CLK_DIV_DEFAULT_DIV = 25'd24_999_999;

endpackage : clk_div_pkg

// File: rtl/clk_div_counter.sv
// Terminal-count counter: counts 0..terminal, then reloads 0.
// tc is high for the whole cycle in which count equals terminal.
module clk_div_counter
   import clk_div_pkg::*;
#(
   parameter cnt_t terminal = CLK_DIV_DEFAULT_DIV
) (
   input  logic clk,
   input  logic rst,
   output cnt_t count,
   output logic tc
);

   // Full-width equality, so the count can never run past terminal.
   assign tc = (count == terminal);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (tc) begin
         count <= '0;
      end else begin
         count <= count + cnt_t'(1);
      end
   end

endmodule : clk_div_counter

// File: rtl/clk_div.sv
// Clock divider: Clk_out is a registered toggle with half-period (counter_div+1) Clk cycles.
// Clk_out is flop data clocked by Clk, never a gated or derived clock.
module clk_div
   import clk_div_pkg::*;
#(
   parameter cnt_t counter_div = CLK_DIV_DEFAULT_DIV
) (
   input  logic Clk,
   input  logic Reset,
   output logic Clk_out
);

   cnt_t count;
   logic tc;

   clk_div_counter #(
      .terminal(counter_div)
   ) u_counter (
      .clk  (Clk),
      .rst  (Reset),
      .count(count),
      .tc   (tc)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Clk_out <= 1'b0;
      end else if (tc) begin
         Clk_out <= ~Clk_out;
      end
   end

endmodule : clk_div

// File: tb/tb_clk_div.sv
// Directed bench for clk_div with counter_div = 3 and counter_div = 0.
// Outputs are sampled on the falling Clk edge, halfway between active edges.
module tb_clk_div;

   logic        Clk   = 1'b0;
   logic        Reset = 1'b0;
   logic        q3;
   logic        q0;
   int          total = 0;
   int          bad   = 0;

   clk_div #(.counter_div(25'd3)) u_div3 (
      .Clk    (Clk),
      .Reset  (Reset),
      .Clk_out(q3)
   );

   clk_div #(.counter_div(25'd0)) u_div0 (
      .Clk    (Clk),
      .Reset  (Reset),
      .Clk_out(q0)
   );

   always #10 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // k = number of rising edges since reset release; hand-derived:
   // div=3 -> high on edges 4..7, 12..15, ...; div=0 -> toggles each edge.
   task automatic run_edges(input string tag, input int n);
      for (int k = 1; k <= n; k++) begin
         @(negedge Clk);
         check({tag, "_q3"}, 32'(q3), 32'((k / 4) % 2));
         check({tag, "_q0"}, 32'(q0), 32'(k % 2));
         check({tag, "_cnt3"}, 32'(u_div3.count), 32'(k % 4));
      end
   endtask

   initial begin
      #1 Reset = 1'b1;
      #4;
      check("rst_imm_q3", 32'(q3), 32'd0);
      check("rst_imm_q0", 32'(q0), 32'd0);

      // Held reset with the clock running keeps everything at zero.
      for (int i = 0; i < 100; i++) begin
         @(negedge Clk);
         check("rst_hold_q3", 32'(q3), 32'd0);
         check("rst_hold_q0", 32'(q0), 32'd0);
         check("rst_hold_cnt3", 32'(u_div3.count), 32'd0);
      end

      Reset = 1'b0;
      run_edges("run", 29);

      // Edge 29: Clk_out high, counter 1. Abort mid high phase between edges.
      #3 Reset = 1'b1;
      #1;
      check("abort_hi_q3", 32'(q3), 32'd0);
      check("abort_hi_cnt3", 32'(u_div3.count), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         check("abort_hold_q3", 32'(q3), 32'd0);
      end
      Reset = 1'b0;
      run_edges("rerun", 10);

      // Edge 10: Clk_out low, counter 2. Abort mid low phase.
      #3 Reset = 1'b1;
      #1;
      check("abort_lo_q3", 32'(q3), 32'd0);
      check("abort_lo_cnt3", 32'(u_div3.count), 32'd0);
      check("abort_lo_q0", 32'(q0), 32'd0);
      @(negedge Clk);
      Reset = 1'b0;
      run_edges("rerun2", 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_clk_div

// File: doc/clk_div.md
CLK_DIV -- requirements
Module: clk_div

Interface
REQ-001 Parameter counter_div, default 25'd24_999_999, 25-bit terminal count; output half-period is (counter_div+1) input cycles.
REQ-002 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
REQ-004 Clk_out  output  1  divided clock, registered, 50% duty cycle.

Function
REQ-005 The block SHALL hold a 25-bit counter and a 1-bit output register driving Clk_out directly (no combinational path to Clk_out).
REQ-006 On each rising Clk edge with Reset low and counter != counter_div, the counter SHALL increment by 1 and Clk_out SHALL hold.
REQ-007 On a rising Clk edge with Reset low and counter == counter_div, the counter SHALL load 0 and Clk_out SHALL invert, in the same edge.
REQ-008 Clk_out period SHALL be exactly 2*(counter_div+1) Clk cycles, high and low phases each (counter_div+1) cycles.
REQ-009 After Reset deasserts, the first Clk_out rising transition SHALL occur on the (counter_div+1)-th rising Clk edge.
REQ-010 counter_div = 0 SHALL produce Clk_out toggling every rising edge (Clk/2).
REQ-011 The counter SHALL never exceed counter_div; there is no wrap-around through 2^25 and no overflow flag.
REQ-012 Comparison SHALL be equality at full 25-bit width; counter_div is static (elaboration-time), so no runtime changes need handling.
REQ-013 50 MHz input with counter_div = 249_999 SHALL yield 100 Hz; default counter_div yields 1 Hz.

Reset
REQ-014 Reset high SHALL immediately (no clock edge required) force counter to 0 and Clk_out to 0.
REQ-015 While Reset is held high, Clk_out SHALL stay 0 and the counter SHALL stay 0 regardless of Clk activity.
REQ-016 Reset asserted mid-period (Clk_out high or low) SHALL abort the period; counting restarts from 0 after deassertion per REQ-009.
REQ-017 Reset released coincident with a Clk edge: that edge SHALL be ignored; counting starts on the next edge.

Structure
REQ-018 A shared package SHALL hold CLK_DIV_CNT_W = 25 and the default terminal count constant 25'd24_999_999.
REQ-019 One sub-module, clk_div_counter (25-bit counter with async reset, terminal-count compare and tc pulse output), SHALL be instantiated; the top holds the toggle register.
REQ-020 No latches, no gated or derived clocks inside the block; Clk_out is data from a flop clocked by Clk.

Verification
REQ-021 counter_div=3, 20 ns Clk, Reset high 20 ns then low -> Clk_out rises on 4th rising edge after release, period 8 cycles (160 ns), 4 high / 4 low.
REQ-022 counter_div=0 -> Clk_out toggles every rising edge, period 40 ns, starting low after reset.
REQ-023 counter_div=249_999, 20 ns Clk, run 2 s -> Clk_out half-period 5 ms, period 10 ms, 200 full cycles, first rise at 5 ms + reset time.
REQ-024 counter_div=3, assert Reset asynchronously between edges while Clk_out=1 -> Clk_out 0 at the same timestep; after release the first rise is again 4 edges later.
REQ-025 Reset held high for 100 cycles with Clk running -> Clk_out constantly 0; counter observed 0.
